// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine: FSM state type, parity helper, DATA_W bounds.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int UART_DATA_W_MIN = 5;
  localparam int UART_DATA_W_MAX = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    ,
    BREAK
`endif
  } uart_tx_state_t;

  // Even parity is the XOR of the word; odd parity inverts it.
  function automatic logic parity(input logic [UART_DATA_W_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 while enabled, restarts on clr.
// bit_end marks the last cycle of a bit, near_end the cycle before it.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end,
  output logic near_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_end  = en && (cnt == LAST);
  assign near_end = en && (cnt == PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the brk input and a line-break state.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic              stop2,
`ifdef UART_TX_BREAK_EN
  input  logic              brk,
`endif
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int BCW = $clog2(DATA_W);

  uart_tx_state_t    state;
  logic [DATA_W-1:0] shreg;
  logic [BCW-1:0]    bit_cnt;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              bit_end;
  logic              near_end;
  logic              last_stop;
  logic              accept;
  logic              in_frame;
  logic              brk_req;

`ifdef UART_TX_BREAK_EN
  assign brk_req = brk;
`else
  assign brk_req = 1'b0;
`endif

  assign last_stop = (state == STOP) && (bit_cnt == BCW'(stop2_q));
  // A pending break also blocks a back-to-back word so the break starts once the frame ends.
  assign s_ready   = !brk_req && ((state == IDLE) || (last_stop && bit_end));
  assign accept    = s_valid && s_ready;
  assign in_frame  = state inside {START, DATA, PARITY, STOP};

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (in_frame),
    .bit_end (bit_end),
    .near_end(near_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_stop && near_end;
      if (accept) begin
        state     <= START;
        shreg     <= s_data;
        par_en_q  <= par_en;
        par_bit_q <= parity(UART_DATA_W_MAX'(s_data), par_odd);
        stop2_q   <= stop2;
        bit_cnt   <= '0;
        tx_out    <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (brk) begin
              state  <= BREAK;
              tx_out <= 1'b0;
              busy   <= 1'b1;
            end
`endif
          end
          START: begin
            if (bit_end) begin
              state  <= DATA;
              tx_out <= shreg[0];
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_cnt == BCW'(DATA_W - 1)) begin
                bit_cnt <= '0;
                if (par_en_q) begin
                  state  <= PARITY;
                  tx_out <= par_bit_q;
                end else begin
                  state  <= STOP;
                  tx_out <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg >> 1;
                tx_out  <= shreg[1];
              end
            end
          end
          PARITY: begin
            if (bit_end) begin
              state   <= STOP;
              bit_cnt <= '0;
              tx_out  <= 1'b1;
            end
          end
          STOP: begin
            if (bit_end) begin
              if (last_stop) begin
                state  <= IDLE;
                tx_out <= 1'b1;
                busy   <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
`ifdef UART_TX_BREAK_EN
          BREAK: begin
            if (!brk) begin
              state  <= IDLE;
              tx_out <= 1'b1;
              busy   <= 1'b0;
            end
          end
`endif
          default: begin
            state  <= IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
